// File: rtl/fifo_pkg.sv
// Shared types, defaults and sizing helpers for the programmable synchronous FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_prog: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [FIFO_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [FIFO_WIDTH-1:0] rdata
);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// arbitrary depth, live fill count and selectable standard or FWFT read mode.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            wr_en,
  input  logic                            rd_en,
  output logic [FIFO_WIDTH-1:0]           data_out,
  output logic                            rd_valid,
  output logic                            wr_ack,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            full,
  output logic                            empty,
  output logic                            almostfull,
  output logic                            almostempty,
  output logic [cnt_w(FIFO_DEPTH)-1:0]    count
);

  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam fifo_mode_e       READ_MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [AW-1:0]    LAST_PTR  = AW'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_THRESH);

  if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2 ||
      AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH - 1 ||
      AE_THRESH < 1 || AE_THRESH > FIFO_DEPTH - 1 ||
      (FWFT != 0 && FWFT != 1)) begin : g_param_error
    $error("sync_fifo_prog: illegal parameters (width/depth/threshold/mode)");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ack_q, wr_ack_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic                  rd_acc;
  logic                  wr_acc;
  logic [FIFO_WIDTH-1:0] mem_rdata;

  // Flags decode only the registered count, so they never glitch.
  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= AF_CNT) && !full;
  assign almostempty = (count_q <= AE_CNT) && !empty;

  always_comb begin
    rd_acc = rd_en && !empty;
    // A full FIFO can still take a write when a read frees a slot this cycle.
    wr_acc = wr_en && (!full || rd_acc);

    wr_ptr_d = wr_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    end

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    wr_ack_d    = wr_acc;
    overflow_d  = wr_en && !wr_acc;
    underflow_d = rd_en && !rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_mem #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  if (READ_MODE == FIFO_STD) begin : g_std_read
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
      dout_d     = rd_acc ? mem_rdata : dout_q;
      rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        dout_q     <= dout_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign data_out = dout_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_fwft_read
    // Head word is presented directly; forced to zero while empty so stale
    // or uninitialised storage never reaches the consumer.
    assign data_out = empty ? '0 : mem_rdata;
    assign rd_valid = !empty;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: three instances (DEPTH 8 std, DEPTH 5 custom thresholds, DEPTH 8 FWFT) checked against a queue scoreboard.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH 8, default thresholds, standard read
  logic [15:0] a_din = '0, a_dout;
  logic a_wr = 1'b0, a_rd = 1'b0;
  logic a_rv, a_ack, a_ov, a_un, a_full, a_empty, a_af, a_ae;
  logic [3:0] a_cnt;

  // Instance B: DEPTH 5, AF 3, AE 2, standard read
  logic [15:0] b_din = '0, b_dout;
  logic b_wr = 1'b0, b_rd = 1'b0;
  logic b_rv, b_ack, b_ov, b_un, b_full, b_empty, b_af, b_ae;
  logic [2:0] b_cnt;

  // Instance C: DEPTH 8, FWFT
  logic [15:0] c_din = '0, c_dout;
  logic c_wr = 1'b0, c_rd = 1'b0;
  logic c_rv, c_ack, c_ov, c_un, c_full, c_empty, c_af, c_ae;
  logic [3:0] c_cnt;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
    .data_out(a_dout), .rd_valid(a_rv), .wr_ack(a_ack), .overflow(a_ov),
    .underflow(a_un), .full(a_full), .empty(a_empty), .almostfull(a_af),
    .almostempty(a_ae), .count(a_cnt)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
    .data_out(b_dout), .rd_valid(b_rv), .wr_ack(b_ack), .overflow(b_ov),
    .underflow(b_un), .full(b_full), .empty(b_empty), .almostfull(b_af),
    .almostempty(b_ae), .count(b_cnt)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .data_in(c_din), .wr_en(c_wr), .rd_en(c_rd),
    .data_out(c_dout), .rd_valid(c_rv), .wr_ack(c_ack), .overflow(c_ov),
    .underflow(c_un), .full(c_full), .empty(c_empty), .almostfull(c_af),
    .almostempty(c_ae), .count(c_cnt)
  );

  // Reference model state
  int          m_cnt [2] = '{0, 0};
  logic [15:0] last_rd [2] = '{16'h0000, 16'h0000};
  logic [15:0] sb_a [$];
  logic [15:0] sb_b [$];
  logic [15:0] sb_c [$];

  // One clocked transaction on a standard-mode instance, checked against the model.
  task automatic step_std(input int inst, input logic wr, input logic rd, input logic [15:0] din);
    int depth, aft, aet, cnt;
    logic rd_acc, wr_acc, e_full, e_empty, e_af, e_ae;
    logic [15:0] dout;
    logic rv, ack, ov, un, fl, em, af, ae;
    depth = (inst == 0) ? 8 : 5;
    aft   = (inst == 0) ? 7 : 3;
    aet   = (inst == 0) ? 1 : 2;
    rd_acc = rd && (m_cnt[inst] != 0);
    wr_acc = wr && ((m_cnt[inst] != depth) || rd_acc);
    if (inst == 0) begin
      a_wr = wr; a_rd = rd; a_din = din;
      if (rd_acc) last_rd[0] = sb_a.pop_front();
      if (wr_acc) sb_a.push_back(din);
    end else begin
      b_wr = wr; b_rd = rd; b_din = din;
      if (rd_acc) last_rd[1] = sb_b.pop_front();
      if (wr_acc) sb_b.push_back(din);
    end
    m_cnt[inst] = m_cnt[inst] + (wr_acc ? 1 : 0) - (rd_acc ? 1 : 0);
    e_full  = (m_cnt[inst] == depth);
    e_empty = (m_cnt[inst] == 0);
    e_af    = (m_cnt[inst] >= aft) && !e_full;
    e_ae    = (m_cnt[inst] <= aet) && !e_empty;

    @(posedge clk);
    #1;
    if (inst == 0) begin
      dout = a_dout; rv = a_rv; ack = a_ack; ov = a_ov; un = a_un;
      fl = a_full; em = a_empty; af = a_af; ae = a_ae; cnt = int'(a_cnt);
      a_wr = 1'b0; a_rd = 1'b0;
    end else begin
      dout = b_dout; rv = b_rv; ack = b_ack; ov = b_ov; un = b_un;
      fl = b_full; em = b_empty; af = b_af; ae = b_ae; cnt = int'(b_cnt);
      b_wr = 1'b0; b_rd = 1'b0;
    end
    $display("txn inst%0d wr=%0b rd=%0b din=%h -> count=%0d dout=%h rv=%0b ack=%0b ov=%0b un=%0b",
             inst, wr, rd, din, cnt, dout, rv, ack, ov, un);

    checks++; if (ack !== wr_acc) begin errors++; $display("FAIL inst%0d wr_ack got %0b exp %0b", inst, ack, wr_acc); end
    checks++; if (ov !== (wr && !wr_acc)) begin errors++; $display("FAIL inst%0d overflow got %0b exp %0b", inst, ov, wr && !wr_acc); end
    checks++; if (un !== (rd && !rd_acc)) begin errors++; $display("FAIL inst%0d underflow got %0b exp %0b", inst, un, rd && !rd_acc); end
    checks++; if (cnt !== m_cnt[inst]) begin errors++; $display("FAIL inst%0d count got %0d exp %0d", inst, cnt, m_cnt[inst]); end
    checks++; if (fl !== e_full) begin errors++; $display("FAIL inst%0d full got %0b exp %0b", inst, fl, e_full); end
    checks++; if (em !== e_empty) begin errors++; $display("FAIL inst%0d empty got %0b exp %0b", inst, em, e_empty); end
    checks++; if (af !== e_af) begin errors++; $display("FAIL inst%0d almostfull got %0b exp %0b", inst, af, e_af); end
    checks++; if (ae !== e_ae) begin errors++; $display("FAIL inst%0d almostempty got %0b exp %0b", inst, ae, e_ae); end
    checks++; if (rv !== rd_acc) begin errors++; $display("FAIL inst%0d rd_valid got %0b exp %0b", inst, rv, rd_acc); end
    checks++; if (dout !== last_rd[inst]) begin errors++; $display("FAIL inst%0d data_out got %h exp %h", inst, dout, last_rd[inst]); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    $display("txn reset released");
    checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
    checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %0b%0b exp 10", a_empty, a_full); end
    checks++; if (a_af !== 1'b0 || a_ae !== 1'b0) begin errors++; $display("FAIL reset_thresh got %0b%0b exp 00", a_af, a_ae); end
    checks++; if ({a_rv, a_ack, a_ov, a_un} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {a_rv, a_ack, a_ov, a_un}); end
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL reset_data_out got %h exp 0000", a_dout); end
    checks++; if (c_rv !== 1'b0 || c_empty !== 1'b1) begin errors++; $display("FAIL reset_fwft got rv=%0b empty=%0b exp rv=0 empty=1", c_rv, c_empty); end
    step_std(0, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) step_std(0, 1'b1, 1'b0, 16'(i));
    step_std(0, 1'b1, 1'b0, 16'hDEAD);
  endtask

  task automatic test_full_rw();
    step_std(0, 1'b1, 1'b1, 16'h00AA);
    for (int i = 0; i < 8; i++) step_std(0, 1'b0, 1'b1, 16'h0000);
    step_std(0, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) step_std(1, 1'b1, 1'b0, 16'(16'h0100 * (r + 1) + i));
      step_std(1, 1'b1, 1'b0, 16'hBAD0);
      for (int i = 0; i < 5; i++) step_std(1, 1'b0, 1'b1, 16'h0000);
    end
    for (int i = 0; i < 3; i++) step_std(1, 1'b1, 1'b0, 16'(16'h0300 + i));
    step_std(1, 1'b1, 1'b1, 16'h0303);
    for (int i = 0; i < 2; i++) step_std(1, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) step_std(1, 1'b1, 1'b0, 16'(16'h0310 + i));
    for (int i = 0; i < 5; i++) step_std(1, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic test_fwft();
    c_din = 16'h1234; c_wr = 1'b1; sb_c.push_back(16'h1234);
    @(posedge clk); #1;
    c_wr = 1'b0;
    $display("txn fwft write 1234 -> rv=%0b dout=%h count=%0d", c_rv, c_dout, c_cnt);
    checks++; if (c_rv !== 1'b1) begin errors++; $display("FAIL fwft_valid got %0b exp 1", c_rv); end
    checks++; if (c_dout !== sb_c[0]) begin errors++; $display("FAIL fwft_head got %h exp %h", c_dout, sb_c[0]); end
    @(posedge clk); #1;
    $display("txn fwft idle -> rv=%0b dout=%h", c_rv, c_dout);
    checks++; if (c_rv !== 1'b1 || c_dout !== sb_c[0]) begin errors++; $display("FAIL fwft_hold got rv=%0b %h exp rv=1 %h", c_rv, c_dout, sb_c[0]); end
    c_rd = 1'b1; void'(sb_c.pop_front());
    @(posedge clk); #1;
    c_rd = 1'b0;
    $display("txn fwft pop -> rv=%0b empty=%0b", c_rv, c_empty);
    checks++; if (c_empty !== 1'b1 || c_rv !== 1'b0) begin errors++; $display("FAIL fwft_pop got empty=%0b rv=%0b exp empty=1 rv=0", c_empty, c_rv); end
    for (int i = 0; i < 3; i++) begin
      c_din = 16'(16'h00A1 + i); c_wr = 1'b1; sb_c.push_back(c_din);
      @(posedge clk); #1;
      c_wr = 1'b0;
      $display("txn fwft write %h -> head=%h count=%0d", 16'(16'h00A1 + i), c_dout, c_cnt);
    end
    while (sb_c.size() > 0) begin
      checks++; if (c_dout !== sb_c[0] || c_rv !== 1'b1) begin errors++; $display("FAIL fwft_order got rv=%0b %h exp rv=1 %h", c_rv, c_dout, sb_c[0]); end
      c_rd = 1'b1; void'(sb_c.pop_front());
      @(posedge clk); #1;
      c_rd = 1'b0;
      $display("txn fwft pop -> head=%h count=%0d", c_dout, c_cnt);
    end
    checks++; if (c_empty !== 1'b1 || c_cnt !== 4'd0) begin errors++; $display("FAIL fwft_drain got empty=%0b count=%0d exp empty=1 count=0", c_empty, c_cnt); end
    c_rd = 1'b1;
    @(posedge clk); #1;
    c_rd = 1'b0;
    $display("txn fwft read on empty -> un=%0b", c_un);
    checks++; if (c_un !== 1'b1) begin errors++; $display("FAIL fwft_underflow got %0b exp 1", c_un); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step_std(0, 1'b1, 1'b0, 16'(16'h0E00 + i));
    a_wr = 1'b1; a_din = 16'h0EEE;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_wr = 1'b0;
    m_cnt = '{0, 0}; last_rd = '{16'h0000, 16'h0000};
    sb_a.delete(); sb_b.delete(); sb_c.delete();
    $display("txn mid-stream reset -> count=%0d empty=%0b", a_cnt, a_empty);
    checks++; if (a_cnt !== 4'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL midrst_state got count=%0d empty=%0b exp count=0 empty=1", a_cnt, a_empty); end
    checks++; if ({a_rv, a_ack, a_ov, a_un} !== 4'b0000) begin errors++; $display("FAIL midrst_pulses got %b exp 0000", {a_rv, a_ack, a_ov, a_un}); end
    step_std(0, 1'b0, 1'b1, 16'h0000);
    step_std(0, 1'b1, 1'b0, 16'h5555);
    step_std(0, 1'b0, 1'b1, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_wrap();
    test_fwft();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO, the next generation of the team's verified FIFO. It adds programmable almost-full and almost-empty thresholds, non-power-of-two depth, a live fill count, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer logic in one clock domain, and a UVM bench drives it through the team's FIFO interface.

Parameters:
FIFO_WIDTH, 16, data word width in bits (≥1)
FIFO_DEPTH, 8, number of entries (≥2; need not be a power of two)
AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count ≥ AF_THRESH and not full (1..FIFO_DEPTH-1)
AE_THRESH, 1, almostempty asserts when count ≤ AE_THRESH and not empty (1..FIFO_DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
data_in  in  FIFO_WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request (acknowledge in FWFT mode)
data_out  out  FIFO_WIDTH  read data
rd_valid  out  1  data_out holds valid read data
wr_ack  out  1  previous-cycle write accepted
overflow  out  1  previous-cycle write rejected (full)
underflow  out  1  previous-cycle read rejected (empty)
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almostfull  out  1  threshold flag
almostempty  out  1  threshold flag
count  out  CNT_W  current occupancy, CNT_W = $clog2(FIFO_DEPTH+1)

Behaviour:
- Single clock domain. Reset is synchronous and active-high. The clock port is clk; the reset port is rst.
- Reset: wr_ptr = rd_ptr = count = 0; data_out = 0; rd_valid, wr_ack, overflow and underflow = 0; empty = 1; full, almostfull and almostempty = 0. Memory contents are not reset.
- Reset asserted mid-operation discards all contents. The cycle after reset the FIFO is empty and rd_en reports underflow.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). A write into a full FIFO succeeds only when a read is accepted in the same cycle.
- When empty, a simultaneous wr_en and rd_en accepts the write only and flags underflow. There is no bypass.
- count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
- Pointers advance on acceptance. They wrap from FIFO_DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
- wr_ack, overflow and underflow are registered one-cycle pulses:
  - wr_ack <= wr_acc
  - overflow <= wr_en && !wr_acc
  - underflow <= rd_en && !rd_acc
- full, empty, almostfull and almostempty are combinational decodes of the count register. They are glitch-free because they derive only from registered state.
- With defaults, almostfull == (count == DEPTH-1) and almostempty == (count == 1), matching the legacy FIFO.
- FWFT=0:
  - On rd_acc, data_out <= mem[rd_ptr] and rd_valid <= 1; latency is one cycle.
  - Otherwise rd_valid <= 0 and data_out holds its last value.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en pops the head; the next word appears in the same cycle the pointer updates.
  - A word written into an empty FIFO is visible on data_out one cycle after the write edge.
- The parameter check is an elaboration-time error if FIFO_DEPTH < 2 or a threshold is out of range.

Decomposition:
- Package fifo_pkg:
  - function cnt_w(depth) returning $clog2(depth+1)
  - typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e
  - localparam defaults DEF_WIDTH = 16 and DEF_DEPTH = 8
- Sub-module fifo_mem: simple dual-port RAM with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata), parametrised by FIFO_WIDTH and FIFO_DEPTH.
- Top-level sync_fifo_prog holds pointers, the counter, flags and the read-mode register.

Test Plan:
- Reset then rd_en=1 for 1 cycle → underflow=1 next cycle; empty=1, count=0, data_out=0.
- FWFT=0, DEPTH=8: write 0x0001..0x0008, then a 9th write of 0xDEAD:
  - wr_ack pulses ×8 and full=1 at count=8
  - almostfull=1 at count=7 only
  - the 9th write gives overflow=1 and is not stored
- Full FIFO, wr_en=rd_en=1 with data_in=0x00AA → count stays 8; data_out=0x0001 next cycle; 0x00AA is read out last after draining.
- DEPTH=5, AF_THRESH=3, AE_THRESH=2: fill and drain twice across the pointer wrap:
  - almostfull=1 at counts 3–4
  - almostempty=1 at counts 1–2
  - output order is preserved across the 4→0 wrap
- FWFT=1: write 0x1234 into an empty FIFO → next cycle rd_valid=1 and data_out=0x1234 with no rd_en; a single rd_en pulse → empty=1 and rd_valid=0.
- Assert rst with count=5 mid-stream → next cycle count=0, empty=1, all pulse outputs 0; a subsequent write/read returns the new data only.
